// File: rtl/key_event_reader_if.sv
// Event handshake between the key event reader (slave) and the game/judge consumer (master).
interface key_event_reader_if;
  logic       EV_RDY;
  logic       EV_ACK;
  logic [1:0] EV_LANE;
  logic       EV_PRESS;

  modport slave  (output EV_RDY, output EV_LANE, output EV_PRESS, input  EV_ACK);
  modport master (input  EV_RDY, input  EV_LANE, input  EV_PRESS, output EV_ACK);
endinterface

// File: rtl/key_event_reader.sv
// Debounces four key lanes, turns stable transitions into press/release events
// and queues them in a show-ahead FIFO drained by a ready/ack handshake.
module key_event_reader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                C,
  input  logic                INIT_N,
  input  logic [3:0]          KEY,
  input  logic                OVF_CLR,
  output logic [3:0]          KEY_STABLE,
  output logic                OVF,
  key_event_reader_if.slave   ev
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [3:0]    stable_q, stable_d;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    dir_q, dir_d;
  logic [2:0]    cnt_q [4];
  logic [2:0]    cnt_d [4];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    mem_q [FIFO_DEPTH];

  logic [1:0]    sel;
  logic          any_pend, full, pop, push, overwrite;
  logic [2:0]    head;

  // Push arbitration looks only at the pending state from before this edge.
  always_comb begin
    sel      = '0;
    any_pend = |pend_q;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) sel = 2'(i);
    end
    full = (count_q == CW'(FIFO_DEPTH));
    pop  = ev.EV_ACK && (count_q != '0);
    push = any_pend && (!full || pop);
  end

  always_comb begin
    stable_d  = stable_q;
    pend_d    = pend_q;
    dir_d     = dir_q;
    overwrite = 1'b0;
    if (push) pend_d[sel] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (KEY[i] != stable_q[i]) begin
        if (cnt_q[i] == 3'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = ~stable_q[i];
          dir_d[i]    = ~stable_q[i];
          pend_d[i]   = 1'b1;
          // An event still waiting (and not leaving this edge) gets replaced.
          if (pend_q[i] && !(push && sel == 2'(i))) overwrite = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end
    end
    ovf_d = overwrite ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) begin
      stable_q <= '0;
      pend_q   <= '0;
      dir_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      stable_q <= stable_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge C) begin
    if (push) mem_q[wr_q] <= {sel, dir_q[sel]};
  end

  assign head        = mem_q[rd_q];
  assign ev.EV_RDY   = (count_q != '0);
  assign ev.EV_LANE  = ev.EV_RDY ? head[2:1] : 2'b00;
  assign ev.EV_PRESS = ev.EV_RDY ? head[0]   : 1'b0;
  assign KEY_STABLE  = stable_q;
  assign OVF         = ovf_q;

endmodule

// File: doc/key_event_reader.md
Name: key_event_reader

Overview:
- Consumer side of the 4-lane registered key bus. Reads the 4-bit lane state that the input register captures each clock.
- Debounces each lane and turns each stable transition into a press or release event.
- Queues events in a small show-ahead FIFO. Game/judge logic drains it with a ready/ack handshake.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive mismatching samples needed to accept a lane change (1..7)
FIFO_DEPTH, 4, event queue entries (power of 2, >=2)

Ports:
C  input  1  clock, rising edge
INIT_N  input  1  asynchronous active-low reset
KEY  input  4  registered lane states, 1 = pressed; synchronous to C
EV_ACK  input  1  consumer pops head event (effective only when EV_RDY=1)
OVF_CLR  input  1  clears OVF
EV_RDY  output  1  FIFO non-empty; head event valid
EV_LANE  output  2  head event lane index
EV_PRESS  output  1  head event type: 1 = press, 0 = release
KEY_STABLE  output  4  debounced lane states
OVF  output  1  sticky: an event was lost

Behaviour:
- Reset (INIT_N=0, asynchronous, any time):
  - KEY_STABLE, per-lane counters, pending bits, FIFO pointers and count, EV_RDY, EV_LANE, EV_PRESS and OVF all go to 0.
  - Events in flight are discarded.
  - After release, lanes held high are re-detected as presses after normal debounce.
- Debounce, per lane i, each edge:
  - If KEY[i]==KEY_STABLE[i], cnt[i] goes to 0.
  - Else cnt[i] increments. On the edge where it would reach DEBOUNCE_CYCLES, KEY_STABLE[i] toggles, cnt[i] goes to 0, and pend[i] is set with dir[i] = new KEY_STABLE[i].
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no change and no event.
- Pending overwrite: if lane i flips again while pend[i] is still set, the old pending event is dropped, pend[i]/dir[i] take the new event, and OVF is set.
- Push, each edge:
  - Selects the lowest-index lane with pend set, from the pending state before this edge.
  - Writes {lane, dir} if the FIFO is not full, or if it is full and a pop occurs on the same edge.
  - Clears that pend bit.
  - At most one push per edge; other lanes wait.
  - A lane flipping on the same edge keeps its new pend.
- Pop: EV_ACK with EV_RDY=1 advances the head on the edge. EV_ACK with EV_RDY=0 is ignored.
- Simultaneous push and pop: count is unchanged. This is legal when full and when count=1.
- Outputs:
  - EV_RDY is high when count is non-zero. EV_LANE and EV_PRESS always present the head entry.
  - When empty, EV_LANE and EV_PRESS hold 0.
  - All outputs are registered or decoded from registers only. There is no combinational path from KEY or EV_ACK to any output.
- Latency: KEY changes before edge 1 and is held. KEY_STABLE and pend update at edge DEBOUNCE_CYCLES. The FIFO write happens at edge DEBOUNCE_CYCLES+1, where EV_RDY rises (FIFO empty, no competing lanes).
- Full FIFO: pending events wait in pend[] and are not lost. Loss occurs only via the pending overwrite rule.
- OVF is sticky until OVF_CLR. If a set and OVF_CLR occur on the same edge, set wins.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.

Test Plan:
- Reset with KEY=4'b1111 held, release INIT_N: no event for 3 edges; KEY_STABLE=1111 after edge 4. Then EV_RDY=1 with events lane0..lane3, EV_PRESS=1, pushed in edges 5..8. Ack each in turn: order 0,1,2,3.
- KEY[2] pulsed high for 3 cycles only: KEY_STABLE stays 0, EV_RDY stays 0, OVF=0.
- KEY[1] high held: EV_RDY rises at edge 5 with lane 1 press. Ack, then release KEY[1]: lane 1 release event, EV_PRESS=0.
- Toggle lanes with no acks until the FIFO holds 4 events: EV_RDY stays 1, further events are held in pend. Flip a pending lane again: OVF=1. Assert OVF_CLR: OVF=0. Ack all: remaining events appear in order.
- Full FIFO, pend set, EV_ACK on the same edge: count stays 4 and the pending event enters the tail.
- Assert INIT_N low mid-stream with 3 queued events: EV_RDY=0, KEY_STABLE=0 immediately, no stale events after release.
